// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the parametrised register file:
//   - default geometry (width, depth), register-0 behaviour and the
//     stack-pointer preset used at reset
//   - rd_src_e: the source selected by a read port for its next output
//   - addr_width(): address width for a given register count (ceil log2)
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_NUM_REGS   = 32;
    localparam int RF_ZERO_REG   = 1;
    localparam int RF_SP_INDEX   = 29;
    localparam int RF_SP_RESET   = 252;

    // Where a read port takes its next value from.
    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,  // hardwired zero or out-of-range address
        SRC_WR2    = 2'd1,  // bypass from write port 2
        SRC_WR1    = 2'd2,  // bypass from write port 1
        SRC_STORED = 2'd3   // value held in the array
    } rd_src_e;

    // Ceil log2 with a floor of 1 bit, so NUM_REGS=2 still gets an address.
    function automatic int addr_width(input int num_regs);
        int w;
        w = 1;
        while ((1 << w) < num_regs) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One registered read port of the register file. Selects, in priority order,
// zero (hardwired register 0 or an address beyond NUM_REGS), write-port-2
// data, write-port-1 data, or the stored value, and registers the result.
//
// Ports:
//   Clk         clock, output register updates on posedge
//   Reset       synchronous active-high reset, clears the output
//   i_addr      read address
//   i_stored    array contents at i_addr (0 when out of range)
//   i_wr1_en    write port 1 enable
//   i_wr1_addr  write port 1 address
//   i_wr1_data  write port 1 data
//   i_wr2_en    write port 2 enable
//   i_wr2_addr  write port 2 address
//   i_wr2_data  write port 2 data
//   o_data      registered read data
// -----------------------------------------------------------------------------
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int NUM_REGS   = RF_NUM_REGS,
    parameter int ZERO_REG   = RF_ZERO_REG,
    parameter int ADDR_W     = addr_width(NUM_REGS)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_WIDTH-1:0] i_stored,
    input  logic                  i_wr1_en,
    input  logic [ADDR_W-1:0]     i_wr1_addr,
    input  logic [DATA_WIDTH-1:0] i_wr1_data,
    input  logic                  i_wr2_en,
    input  logic [ADDR_W-1:0]     i_wr2_addr,
    input  logic [DATA_WIDTH-1:0] i_wr2_data,
    output logic [DATA_WIDTH-1:0] o_data
);

    // One extra bit so NUM_REGS itself is representable when it is 2**ADDR_W.
    localparam logic [ADDR_W:0] LP_NUM_REGS = (ADDR_W + 1)'(NUM_REGS);

    logic                  w_in_range;
    logic                  w_is_zero_reg;
    logic                  w_hit1;
    logic                  w_hit2;
    rd_src_e               w_src;
    logic [DATA_WIDTH-1:0] w_next;
    logic [DATA_WIDTH-1:0] r_data;

    assign w_in_range    = ({1'b0, i_addr} < LP_NUM_REGS);
    assign w_is_zero_reg = (ZERO_REG != 0) && (i_addr == '0);
    assign w_hit1        = i_wr1_en && (i_wr1_addr == i_addr);
    assign w_hit2        = i_wr2_en && (i_wr2_addr == i_addr);

    // Zero and out-of-range beat any bypass hit: a dropped write must not
    // leak through the forwarding path.
    always_comb begin
        // NOTE: assign a default before any branch so every path drives the
        // signal and no latch is inferred.
        w_src = SRC_STORED;
        if (!w_in_range || w_is_zero_reg) begin
            w_src = SRC_ZERO;
        end else if (w_hit2) begin
            w_src = SRC_WR2;
        end else if (w_hit1) begin
            w_src = SRC_WR1;
        end
    end

    always_comb begin
        w_next = '0;
        case (w_src)
            SRC_WR2:    w_next = i_wr2_data;
            SRC_WR1:    w_next = i_wr1_data;
            SRC_STORED: w_next = i_stored;
            default:    w_next = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments for every clocked register, so all
        // flops sample their inputs from before the edge.
        if (Reset) begin
            r_data <= '0;
        end else begin
            r_data <= w_next;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/register_file_param.sv
// -----------------------------------------------------------------------------
// register_file_param
// Parametrised register file: two write ports, two registered write-through
// read ports. Register 0 can be hardwired to zero; SP_INDEX is preset to
// SP_RESET on reset. Addresses at or above NUM_REGS write nothing and read 0.
//
// Ports:
//   Clk             clock, all state updates on posedge
//   Reset           synchronous active-high reset
//   ReadRegister1   read port 1 address
//   ReadRegister2   read port 2 address
//   WriteRegister1  write port 1 address
//   WriteData1      write port 1 data
//   RegWrite1       write port 1 enable
//   WriteRegister2  write port 2 address
//   WriteData2      write port 2 data
//   RegWrite2       write port 2 enable (wins over port 1 on the same address)
//   ReadData1       registered read data, port 1
//   ReadData2       registered read data, port 2
// -----------------------------------------------------------------------------
module register_file_param
    import rf_pkg::*;
#(
    parameter int  DATA_WIDTH = RF_DATA_WIDTH,
    parameter int  NUM_REGS   = RF_NUM_REGS,
    parameter int  ZERO_REG   = RF_ZERO_REG,
    parameter int  SP_INDEX   = RF_SP_INDEX,
    parameter int  SP_RESET   = RF_SP_RESET,
    localparam int ADDR_W     = addr_width(NUM_REGS)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_W-1:0]     ReadRegister1,
    input  logic [ADDR_W-1:0]     ReadRegister2,
    input  logic [ADDR_W-1:0]     WriteRegister1,
    input  logic [DATA_WIDTH-1:0] WriteData1,
    input  logic                  RegWrite1,
    input  logic [ADDR_W-1:0]     WriteRegister2,
    input  logic [DATA_WIDTH-1:0] WriteData2,
    input  logic                  RegWrite2,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    // Stop elaboration on an impossible configuration.
    if (NUM_REGS < 2 || NUM_REGS > 256) begin : g_bad_num_regs
        $error("register_file_param: NUM_REGS=%0d outside 2..256", NUM_REGS);
    end
    if (SP_INDEX < 0 || SP_INDEX >= NUM_REGS) begin : g_bad_sp_index
        $error("register_file_param: SP_INDEX=%0d must be below NUM_REGS=%0d",
               SP_INDEX, NUM_REGS);
    end

    localparam logic [DATA_WIDTH-1:0] LP_SP_RESET = DATA_WIDTH'(SP_RESET);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_stored1;
    logic [DATA_WIDTH-1:0] w_stored2;

    // Storage and write logic. Each entry decodes both write ports itself;
    // port 2 is tested first so it wins a same-address collision. Addresses
    // beyond NUM_REGS match no entry and are dropped.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            // NOTE: this array is architectural state built from flops, so
            // every entry is reset; it is not meant to map onto a RAM macro.
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (i == SP_INDEX) ? LP_SP_RESET : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (!(ZERO_REG != 0 && i == 0)) begin
                    if (RegWrite2 && WriteRegister2 == ADDR_W'(i)) begin
                        r_regs[i] <= WriteData2;
                    end else if (RegWrite1 && WriteRegister1 == ADDR_W'(i)) begin
                        r_regs[i] <= WriteData1;
                    end
                end
            end
        end
    end

    // Array lookup by decode instead of direct indexing, so an address beyond
    // NUM_REGS yields a defined 0 rather than an out-of-bounds access.
    always_comb begin
        w_stored1 = '0;
        w_stored2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ReadRegister1 == ADDR_W'(i)) begin
                w_stored1 = r_regs[i];
            end
            if (ReadRegister2 == ADDR_W'(i)) begin
                w_stored2 = r_regs[i];
            end
        end
    end

    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ZERO_REG   (ZERO_REG),
        .ADDR_W     (ADDR_W)
    ) u_read_port1 (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_addr     (ReadRegister1),
        .i_stored   (w_stored1),
        .i_wr1_en   (RegWrite1),
        .i_wr1_addr (WriteRegister1),
        .i_wr1_data (WriteData1),
        .i_wr2_en   (RegWrite2),
        .i_wr2_addr (WriteRegister2),
        .i_wr2_data (WriteData2),
        .o_data     (ReadData1)
    );

    rf_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ZERO_REG   (ZERO_REG),
        .ADDR_W     (ADDR_W)
    ) u_read_port2 (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_addr     (ReadRegister2),
        .i_stored   (w_stored2),
        .i_wr1_en   (RegWrite1),
        .i_wr1_addr (WriteRegister1),
        .i_wr1_data (WriteData1),
        .i_wr2_en   (RegWrite2),
        .i_wr2_addr (WriteRegister2),
        .i_wr2_data (WriteData2),
        .o_data     (ReadData2)
    );

endmodule
